// File: rtl/program_memory_arbiter_if.sv
// Requester, response and program-memory bus signals of the two-port
// program memory arbiter. The arbiter uses the slave view.
interface program_memory_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                   mem_enable_in;
  logic [1:0]             req_valid_in;
  logic [1:0][ADDR_W-1:0] req_addr_in;
  logic [1:0]             req_ready_out;
  logic [1:0]             rsp_valid_out;
  logic [DATA_W-1:0]      rsp_instr_out;
  logic [ADDR_W-1:0]      mem_addr_out;
  logic                   mem_read_request_out;
  logic [DATA_W-1:0]      mem_instr_in;
  logic                   mem_data_valid_in;
  logic                   protocol_err_out;

  modport master (
    output mem_enable_in, req_valid_in, req_addr_in, mem_instr_in, mem_data_valid_in,
    input  req_ready_out, rsp_valid_out, rsp_instr_out, mem_addr_out,
           mem_read_request_out, protocol_err_out
  );

  modport slave (
    input  mem_enable_in, req_valid_in, req_addr_in, mem_instr_in, mem_data_valid_in,
    output req_ready_out, rsp_valid_out, rsp_instr_out, mem_addr_out,
           mem_read_request_out, protocol_err_out
  );
endinterface

// File: rtl/program_memory_arbiter.sv
// Round-robin arbiter sharing one program-memory read port between two
// requesters; an in-order tag FIFO routes each returning word to its requester.
module program_memory_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic                     clk_in,
  input logic                     rst_n_in,
  program_memory_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MAX_OUTSTANDING);

  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       last_grant;
  logic [ADDR_W-1:0]          addr_q;
  logic                       err_q;

  logic       fifo_empty;
  logic       room;
  logic       winner;
  logic       push;
  logic       pop;
  logic [1:0] ready;

  // A full FIFO may still accept a grant when a pop frees a slot this cycle.
  always_comb begin
    fifo_empty = (count == '0);
    pop        = rst_n_in && bus.mem_data_valid_in && !fifo_empty;
    room       = (count < DEPTH) || bus.mem_data_valid_in;
    winner     = (bus.req_valid_in == 2'b11) ? ~last_grant : bus.req_valid_in[1];
    ready      = '0;
    if (rst_n_in && bus.mem_enable_in && room && (bus.req_valid_in != 2'b00))
      ready[winner] = 1'b1;
    push       = |ready;
  end

  assign bus.req_ready_out        = ready;
  assign bus.mem_read_request_out = push;
  assign bus.mem_addr_out         = push ? bus.req_addr_in[winner] : addr_q;
  assign bus.rsp_valid_out        = pop ? (tag_q[rd_ptr] ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_instr_out        = bus.mem_instr_in;
  assign bus.protocol_err_out     = err_q;

  always_ff @(posedge clk_in) begin
    if (push)
      tag_q[wr_ptr] <= winner;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        last_grant <= winner;
        addr_q     <= bus.req_addr_in[winner];
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (bus.mem_data_valid_in && fifo_empty)
        err_q <= 1'b1;
    end
  end
endmodule
